nv_ram_fifo_ctrl_80x65: RTL and testbench
=========================================

# nv_ram_fifo_ctrl_80x65

Flow-controlled FIFO controller that sequences an 80-entry x 65-bit two-port register-file RAM (registered read address, registered output data) into a valid/ready FIFO. It owns the write/read pointers, occupancy accounting and the two-stage read pipeline (`re` then `ore`). It sits between a producer and consumer in a core datapath and drives the RAM ports directly; the RAM instance lives alongside it in the parent.

## Interface
- `DEPTH`, 80: entry count; pointers wrap `DEPTH-1 -> 0`. Not a power of two.
- `WIDTH`, 65: payload width.
- `clk`  in  1  sole clock, rising edge.
- `reset`  in  1  asynchronous, active-high; clears all controller state.
- `wr_pvld`  in  1  producer data valid.
- `wr_prdy`  out  1  controller can accept; write happens when `wr_pvld & wr_prdy`.
- `wr_pd`  in  65  write payload.
- `rd_pvld`  out  1  output data valid.
- `rd_prdy`  in  1  consumer ready; pop when `rd_pvld & rd_prdy`.
- `rd_pd`  out  65  output payload (= `ram_dout`).
- `ram_wa`, `ram_ra`  out  7  RAM write/read address.
- `ram_we`, `ram_re`, `ram_ore`  out  1  RAM write enable, read-address capture enable, output-register enable.
- `ram_di`  out  65  RAM write data (= `wr_pd`).
- `ram_dout`  in  65  RAM registered output.
- `pwrbus_ram_pd`  in  32  forwarded unchanged on `ram_pwrbus_ram_pd`  out  32.
- `peak_count`  out  7  high-water occupancy (see Configuration).

## Operation
- State: `wr_ptr`, `rd_ptr` (7b, 0..79), `occ` (7b, 0..80, entries not yet moved to RAM output register), `avail` (7b, written entries not yet issued), `s1` (address stage valid), `s2` (output stage valid).
- Write: `wr_prdy = (occ != 80)`. `ram_we = wr_pvld & wr_prdy`, `ram_wa = wr_ptr`, `ram_di = wr_pd`. On write, `wr_ptr` advances, wrapping 79 -> 0.
- Issue: `ram_ore = s1 & (!s2 | rd_prdy)`. `ram_re = (avail != 0) & (!s1 | ram_ore)`; `ram_ra = rd_ptr`; on `ram_re`, `rd_ptr` advances with wrap, `s1 <= 1`; else if `ram_ore`, `s1 <= 0`.
- Output: `s2 <= ram_ore ? 1 : (rd_prdy ? 0 : s2)`. `rd_pvld = s2`, `rd_pd = ram_dout`.
- Counters: `avail += we - re`; `occ += we - ore`. Simultaneous inc/dec leaves value unchanged. Entry slot freed at `ram_ore`, so a write to an address never collides with a pending read.
- Stall: `ram_re = 0` and `ram_ore = 0` keep RAM address and output registers unchanged, so `rd_pd` is stable while `rd_pvld & !rd_prdy`.
- Reset (any time, incl. mid-transfer): pointers, counters, `s1`, `s2`, `peak_count` go to 0. So `wr_prdy = 1`, `rd_pvld = 0`, all RAM enables are 0. RAM contents and `rd_pd` are undefined and are not cleared.

## Timing
- Write accepted at end of cycle 0: `ram_re` in cycle 1, `ram_ore` in cycle 2, `rd_pvld = 1` with the data in cycle 3. Minimum latency is 3 cycles.
- Sustained 1 write + 1 pop per cycle with no bubbles while `rd_prdy = 1`.
- `wr_prdy` depends only on registered `occ`. `ram_re` and `ram_ore` are combinational on `rd_prdy`.
- Capacity is 80 entries in the RAM plus 1 in the output stage. `wr_prdy` rises the cycle after the `ore` that frees a slot.

## Configuration
- `NV_RAM_FIFO_CTRL_80X65_PEAK_EN` defined: `peak_count` registers max(`occ`) since reset. It updates the cycle after `occ` exceeds it and saturates at 80.
- Not defined: `peak_count` is tied to 0 and no peak register is built.

## Test plan
- Reset released, no traffic -> `wr_prdy = 1`, `rd_pvld = 0`, `ram_we/re/ore = 0`, `peak_count = 0`.
- Single write 65'h1_DEAD_BEEF_0000_0001 in cycle 0, `rd_prdy = 1` -> `ram_re` in cycle 1 with `ram_ra = 0`, `ram_ore` in cycle 2, `rd_pvld` with that data in cycle 3.
- `rd_prdy = 0`, 82 writes offered -> 81 accepted (80 RAM + 1 output stage), `wr_prdy = 0` after that, `rd_pd` stable. Then one pop -> `wr_prdy = 1` the following cycle.
- 500 transfers with random `wr_pvld`/`rd_prdy` -> in-order data, no loss or duplication, `ram_wa`/`ram_ra` wrap 79 -> 0, never exceed 79.
- `reset` asserted with `occ = 40` and `s1 = s2 = 1` -> same cycle `rd_pvld = 0`, `wr_prdy = 1`. After release, the next write's data is the first data popped.
- With `NV_RAM_FIFO_CTRL_80X65_PEAK_EN`: fill to 57 then drain -> `peak_count = 57` held. Without it -> `peak_count = 0`.

Source files
------------

// File: rtl/nv_ram_fifo_ctrl_80x65.sv
// nv_ram_fifo_ctrl_80x65
// Valid/ready FIFO controller for an 80 x 65 two-port register-file RAM.
// The RAM has a registered read address and a registered output.
// The controller owns the write and read pointers, the occupancy counters
// and the two-stage read pipeline: re (address capture), then ore (output capture).
// Optional build macro: NV_RAM_FIFO_CTRL_80X65_PEAK_EN
//   When defined, peak_count holds the highest occ seen since reset.
//   When undefined, peak_count is tied to 0 and no peak register is built.
module nv_ram_fifo_ctrl_80x65 #(
  parameter int DEPTH = 80,
  parameter int WIDTH = 65
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_pvld,
  output logic             wr_prdy,
  input  logic [WIDTH-1:0] wr_pd,
  output logic             rd_pvld,
  input  logic             rd_prdy,
  output logic [WIDTH-1:0] rd_pd,
  output logic [6:0]       ram_wa,
  output logic             ram_we,
  output logic [WIDTH-1:0] ram_di,
  output logic [6:0]       ram_ra,
  output logic             ram_re,
  output logic             ram_ore,
  input  logic [WIDTH-1:0] ram_dout,
  input  logic [31:0]      pwrbus_ram_pd,
  output logic [31:0]      ram_pwrbus_ram_pd,
  output logic [6:0]       peak_count
);

  localparam logic [6:0] LAST = 7'(DEPTH - 1);
  localparam logic [6:0] FULL = 7'(DEPTH);

  logic [6:0] wr_ptr_q, wr_ptr_d;
  logic [6:0] rd_ptr_q, rd_ptr_d;
  logic [6:0] occ_q, occ_d;
  logic [6:0] avail_q, avail_d;
  logic       s1_q, s1_d;
  logic       s2_q, s2_d;
  logic       we, re, ore;

  // Handshake and RAM enables.
  // occ still counts an entry until ore moves it into the RAM output register.
  // A write slot therefore never aliases a read that is still pending.
  always_comb begin
    wr_prdy = (occ_q != FULL);
    we      = wr_pvld & wr_prdy;
    ore     = s1_q & (~s2_q | rd_prdy);
    re      = (avail_q != 7'd0) & (~s1_q | ore);
  end

  assign ram_we            = we;
  assign ram_wa            = wr_ptr_q;
  assign ram_di            = wr_pd;
  assign ram_re            = re;
  assign ram_ra            = rd_ptr_q;
  assign ram_ore           = ore;
  assign rd_pvld           = s2_q;
  assign rd_pd             = ram_dout;
  assign ram_pwrbus_ram_pd = pwrbus_ram_pd;

  // Next-state logic: pointers wrap at DEPTH-1, which is not a power of two.
  // When an increment and a decrement land in the same cycle, the count holds.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    avail_d  = avail_q;
    occ_d    = occ_q;
    s1_d     = s1_q;
    s2_d     = s2_q;
    if (we) wr_ptr_d = (wr_ptr_q == LAST) ? 7'd0 : wr_ptr_q + 7'd1;
    if (re) rd_ptr_d = (rd_ptr_q == LAST) ? 7'd0 : rd_ptr_q + 7'd1;
    case ({we, re})
      2'b10:   avail_d = avail_q + 7'd1;
      2'b01:   avail_d = avail_q - 7'd1;
      default: avail_d = avail_q;
    endcase
    case ({we, ore})
      2'b10:   occ_d = occ_q + 7'd1;
      2'b01:   occ_d = occ_q - 7'd1;
      default: occ_d = occ_q;
    endcase
    if (re)       s1_d = 1'b1;
    else if (ore) s1_d = 1'b0;
    if (ore)          s2_d = 1'b1;
    else if (rd_prdy) s2_d = 1'b0;
  end

  // Controller state register; reset clears everything except RAM contents.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= 7'd0;
      rd_ptr_q <= 7'd0;
      avail_q  <= 7'd0;
      occ_q    <= 7'd0;
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      avail_q  <= avail_d;
      occ_q    <= occ_d;
      s1_q     <= s1_d;
      s2_q     <= s2_d;
    end
  end

`ifdef NV_RAM_FIFO_CTRL_80X65_PEAK_EN
  logic [6:0] peak_q, peak_d;

  // High-water mark; it trails occ by one cycle and cannot exceed FULL.
  always_comb begin
    peak_d = (occ_q > peak_q) ? occ_q : peak_q;
  end

  // Peak register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) peak_q <= 7'd0;
    else       peak_q <= peak_d;
  end

  assign peak_count = peak_q;
`else
  assign peak_count = 7'd0;
`endif

endmodule

// File: tb/tb_nv_ram_fifo_ctrl_80x65.sv
// Testbench for nv_ram_fifo_ctrl_80x65.
// A behavioural RAM is attached to the controller.
// Expected data is held in a scoreboard queue: pushed on accepted writes, popped on reads.
module tb_nv_ram_fifo_ctrl_80x65;

  logic        clk = 1'b0;
  logic        reset;
  logic        wr_pvld;
  logic        wr_prdy;
  logic [64:0] wr_pd;
  logic        rd_pvld;
  logic        rd_prdy;
  logic [64:0] rd_pd;
  logic [6:0]  ram_wa;
  logic        ram_we;
  logic [64:0] ram_di;
  logic [6:0]  ram_ra;
  logic        ram_re;
  logic        ram_ore;
  logic [64:0] ram_dout;
  logic [31:0] pwrbus_ram_pd;
  logic [31:0] ram_pwrbus_ram_pd;
  logic [6:0]  peak_count;

  int n_checks = 0;
  int n_fail   = 0;

  logic [64:0] sb[$];
  int          exp_wa;
  int          exp_ra;

  nv_ram_fifo_ctrl_80x65 dut (
    .clk               (clk),
    .reset             (reset),
    .wr_pvld           (wr_pvld),
    .wr_prdy           (wr_prdy),
    .wr_pd             (wr_pd),
    .rd_pvld           (rd_pvld),
    .rd_prdy           (rd_prdy),
    .rd_pd             (rd_pd),
    .ram_wa            (ram_wa),
    .ram_we            (ram_we),
    .ram_di            (ram_di),
    .ram_ra            (ram_ra),
    .ram_re            (ram_re),
    .ram_ore           (ram_ore),
    .ram_dout          (ram_dout),
    .pwrbus_ram_pd     (pwrbus_ram_pd),
    .ram_pwrbus_ram_pd (ram_pwrbus_ram_pd),
    .peak_count        (peak_count)
  );

  always #5 clk = ~clk;

  // Behavioural RAM: registered read address, registered output data.
  logic [64:0] mem [0:79];
  logic [6:0]  ra_q;
  always @(posedge clk) begin
    if (ram_we && ram_wa < 7'd80) mem[ram_wa] <= ram_di;
    if (ram_re) ra_q <= ram_ra;
    if (ram_ore) ram_dout <= (ra_q < 7'd80) ? mem[ra_q] : 65'hx;
  end

  // Drive the inputs for one cycle, then check addresses and popped data before the edge.
  task automatic step(input logic v, input logic [64:0] d, input logic r,
                      output logic acc, output logic popd);
    logic [64:0] e;
    wr_pvld = v; wr_pd = d; rd_prdy = r;
    #1;
    acc  = wr_pvld & wr_prdy;
    popd = rd_pvld & rd_prdy;
    if (acc) begin
      n_checks++;
      if (ram_wa !== 7'(exp_wa)) begin
        n_fail++;
        $display("FAIL wr_addr: got %0d want %0d", ram_wa, exp_wa);
      end
      exp_wa = (exp_wa == 79) ? 0 : exp_wa + 1;
      sb.push_back(d);
    end
    if (ram_re) begin
      n_checks++;
      if (ram_ra !== 7'(exp_ra)) begin
        n_fail++;
        $display("FAIL rd_addr: got %0d want %0d", ram_ra, exp_ra);
      end
      exp_ra = (exp_ra == 79) ? 0 : exp_ra + 1;
    end
    if (popd) begin
      n_checks++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL pop_empty: got %h want no pop", rd_pd);
      end else begin
        e = sb.pop_front();
        if (rd_pd !== e) begin
          n_fail++;
          $display("FAIL pop_data: got %h want %h", rd_pd, e);
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic cyc(input logic v, input logic [64:0] d, input logic r);
    logic a, p;
    step(v, d, r, a, p);
    tick();
  endtask

  task automatic do_reset();
    reset = 1'b1; wr_pvld = 1'b0; rd_prdy = 1'b0; wr_pd = '0;
    sb.delete(); exp_wa = 0; exp_ra = 0;
    repeat (2) tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic drain();
    int budget = 400;
    while ((sb.size() != 0 || rd_pvld) && budget > 0) begin
      cyc(1'b0, '0, 1'b1);
      budget--;
    end
    n_checks++;
    if (budget == 0) begin
      n_fail++;
      $display("FAIL drain_timeout: got %0d left want 0", sb.size());
    end
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    n_checks++;
    if ({wr_prdy, rd_pvld, ram_we, ram_re, ram_ore} !== 5'b10000) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b want 10000", {wr_prdy, rd_pvld, ram_we, ram_re, ram_ore});
    end
    n_checks++;
    if (peak_count !== 7'd0) begin
      n_fail++;
      $display("FAIL reset_peak: got %0d want 0", peak_count);
    end
    pwrbus_ram_pd = 32'hA5C3_0F1E;
    #1;
    n_checks++;
    if (ram_pwrbus_ram_pd !== 32'hA5C3_0F1E) begin
      n_fail++;
      $display("FAIL pwrbus: got %h want a5c30f1e", ram_pwrbus_ram_pd);
    end
    tick();
  endtask

  task automatic test_single();
    logic a, p;
    logic [64:0] d = 65'h1_DEAD_BEEF_0000_0001;
    step(1'b1, d, 1'b1, a, p);
    n_checks++;
    if (a !== 1'b1 || ram_re !== 1'b0) begin
      n_fail++;
      $display("FAIL single_c0: got acc=%b re=%b want acc=1 re=0", a, ram_re);
    end
    tick();
    step(1'b0, '0, 1'b1, a, p);
    n_checks++;
    if (ram_re !== 1'b1 || ram_ra !== 7'd0 || ram_ore !== 1'b0) begin
      n_fail++;
      $display("FAIL single_c1: got re=%b ra=%0d ore=%b want 1 0 0", ram_re, ram_ra, ram_ore);
    end
    tick();
    step(1'b0, '0, 1'b1, a, p);
    n_checks++;
    if (ram_ore !== 1'b1 || rd_pvld !== 1'b0) begin
      n_fail++;
      $display("FAIL single_c2: got ore=%b pvld=%b want 1 0", ram_ore, rd_pvld);
    end
    tick();
    step(1'b0, '0, 1'b1, a, p);
    n_checks++;
    if (rd_pvld !== 1'b1 || rd_pd !== d) begin
      n_fail++;
      $display("FAIL single_c3: got pvld=%b pd=%h want 1 %h", rd_pvld, rd_pd, d);
    end
    tick();
  endtask

  task automatic test_full();
    logic a, p;
    int acc_n = 0;
    logic [64:0] held;
    logic have = 1'b0;
    for (int i = 0; i < 82; i++) begin
      step(1'b1, {33'(i), 32'hF00D_0000 + 32'(i)}, 1'b0, a, p);
      if (a) acc_n++;
      if (rd_pvld) begin
        if (!have) begin held = rd_pd; have = 1'b1; end
        else begin
          n_checks++;
          if (rd_pd !== held) begin
            n_fail++;
            $display("FAIL stall_stable: got %h want %h", rd_pd, held);
          end
        end
      end
      tick();
    end
    if (a) sb.pop_back();
    n_checks++;
    if (acc_n !== 81) begin
      n_fail++;
      $display("FAIL full_count: got %0d want 81", acc_n);
    end
    #0;
    n_checks++;
    if (wr_prdy !== 1'b0) begin
      n_fail++;
      $display("FAIL full_prdy: got %b want 0", wr_prdy);
    end
    n_checks++;
`ifdef NV_RAM_FIFO_CTRL_80X65_PEAK_EN
    if (peak_count !== 7'd80) begin
      n_fail++;
      $display("FAIL full_peak: got %0d want 80", peak_count);
    end
`else
    if (peak_count !== 7'd0) begin
      n_fail++;
      $display("FAIL full_peak: got %0d want 0", peak_count);
    end
`endif
    cyc(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b0, a, p);
    n_checks++;
    if (wr_prdy !== 1'b1) begin
      n_fail++;
      $display("FAIL refill_prdy: got %b want 1", wr_prdy);
    end
    tick();
    drain();
  endtask

  task automatic test_random();
    logic a, p;
    int pops = 0;
    int budget = 6000;
    int sent = 0;
    while (pops < 500 && budget > 0) begin
      step(($urandom_range(0, 3) != 0) && sent < 500,
           {$urandom_range(0, 1) == 1, $urandom(), $urandom()},
           $urandom_range(0, 2) != 0, a, p);
      if (a) sent++;
      if (p) pops++;
      tick();
      budget--;
    end
    n_checks++;
    if (pops !== 500 || sb.size() !== 0) begin
      n_fail++;
      $display("FAIL random_count: got pops=%0d left=%0d want 500 0", pops, sb.size());
    end
  endtask

  task automatic test_reset_mid();
    logic a, p;
    logic [64:0] d = 65'h0_1234_5678_9ABC_DEF0;
    for (int i = 0; i < 41; i++) cyc(1'b1, 65'(i + 1000), 1'b0);
    repeat (3) cyc(1'b0, '0, 1'b0);
    rd_prdy = 1'b1;
    reset = 1'b1;
    #1;
    n_checks++;
    if (rd_pvld !== 1'b0 || wr_prdy !== 1'b1 || ram_re !== 1'b0 || ram_ore !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset: got pvld=%b prdy=%b re=%b ore=%b want 0 1 0 0",
               rd_pvld, wr_prdy, ram_re, ram_ore);
    end
    sb.delete(); exp_wa = 0; exp_ra = 0;
    tick();
    reset = 1'b0;
    tick();
    cyc(1'b1, d, 1'b1);
    for (int i = 0; i < 6; i++) begin
      step(1'b0, '0, 1'b1, a, p);
      if (p) begin
        n_checks++;
        if (rd_pd !== d) begin
          n_fail++;
          $display("FAIL midreset_first: got %h want %h", rd_pd, d);
        end
      end
      tick();
    end
    n_checks++;
    if (sb.size() !== 0) begin
      n_fail++;
      $display("FAIL midreset_drain: got %0d left want 0", sb.size());
    end
  endtask

  task automatic test_peak();
    do_reset();
    for (int i = 0; i < 58; i++) cyc(1'b1, 65'(i * 3), 1'b0);
    drain();
    #1;
    n_checks++;
`ifdef NV_RAM_FIFO_CTRL_80X65_PEAK_EN
    if (peak_count !== 7'd57) begin
      n_fail++;
      $display("FAIL peak_hold: got %0d want 57", peak_count);
    end
`else
    if (peak_count !== 7'd0) begin
      n_fail++;
      $display("FAIL peak_hold: got %0d want 0", peak_count);
    end
`endif
  endtask

  initial begin
    pwrbus_ram_pd = '0;
    test_reset();
    test_single();
    test_full();
    test_random();
    test_reset_mid();
    test_peak();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
